// File: rtl/dbus_mmio_ctrl.sv
// dbus_mmio_ctrl: core data bus splitter to RAM and MMIO registers, with a debug-mode RAM scanner feeding the display.
module dbus_mmio_ctrl #(
  parameter int          DW        = 32,
  parameter int          SYNC_N    = 2,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter int          NREG      = 4,
  parameter logic [31:0] SCAN_BASE = 32'h0000_0200,
  parameter int          SCAN_LEN  = 8,
  parameter int          SCAN_DIV  = 1000000
) (
  input  logic          m_clock,
  input  logic          p_reset,
  input  logic          mode,
  input  logic [31:0]   core_daddr,
  input  logic [DW-1:0] core_wdata,
  input  logic          core_read,
  input  logic          core_write,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  output logic [31:0]   ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_rden,
  output logic          ram_wren,
  input  logic [DW-1:0] ram_rdata,
  output logic [DW-1:0] disp_data,
  output logic [7:0]    disp_idx,
  output logic          dbg_mode
);
  localparam int IW = SCAN_LEN > 1 ? $clog2(SCAN_LEN) : 1;
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  typedef enum logic [1:0] {SRC_NONE, SRC_RAM, SRC_MMIO} src_t;
  logic [SYNC_N-1:0] sync_q;
  logic [DW-1:0]     regs [NREG];
  logic [DW-1:0]     mmio_q, disp_q, mmio_rd, reg0_next;
  logic [7:0]        idx_q;
  logic [IW-1:0]     scan_idx;
  logic [CW-1:0]     div;
  src_t              src_q;
  logic [31:0]       off;
  logic              is_mmio, run_rd, run_wr, ram_sel, dbg_rise, div_tc;
  assign dbg_mode   = sync_q[SYNC_N-1];
  assign core_stall = dbg_mode;
  assign off        = core_daddr - MMIO_BASE;
  assign is_mmio    = core_daddr >= MMIO_BASE;
  assign run_wr     = !dbg_mode && core_write;
  assign run_rd     = !dbg_mode && core_read && !core_write;
  assign ram_sel    = !dbg_mode && !is_mmio && (core_read || core_write);
  // Clear the scan one cycle early so the first debug cycle already addresses SCAN_BASE.
  assign dbg_rise   = sync_q[SYNC_N-2] && !dbg_mode;
  assign div_tc     = div == CW'(SCAN_DIV - 1);
  assign ram_rden   = dbg_mode || (ram_sel && core_read && !core_write);
  assign ram_wren   = ram_sel && core_write;
  assign ram_addr   = dbg_mode ? SCAN_BASE + 32'({scan_idx, 2'b00}) : ram_sel ? core_daddr : 32'd0;
  assign ram_wdata  = ram_sel ? core_wdata : '0;
  assign core_rdata = src_q == SRC_RAM ? ram_rdata : src_q == SRC_MMIO ? mmio_q : '0;
  assign disp_data  = disp_q;
  assign disp_idx   = idx_q;
  assign reg0_next  = (run_wr && is_mmio && off == 32'd0) ? core_wdata : regs[0];
  always_comb begin
    mmio_rd = '0;
    for (int i = 0; i < NREG; i++) if (is_mmio && off == 32'(4 * i)) mmio_rd = regs[i];
  end
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      sync_q   <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      mmio_q   <= '0;
      src_q    <= SRC_NONE;
      scan_idx <= '0;
      div      <= '0;
      disp_q   <= '0;
      idx_q    <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_N-2:0], mode};
      for (int i = 0; i < NREG; i++) if (run_wr && is_mmio && off == 32'(4 * i)) regs[i] <= core_wdata;
      src_q  <= !run_rd ? SRC_NONE : is_mmio ? SRC_MMIO : SRC_RAM;
      mmio_q <= run_rd ? mmio_rd : '0;
      disp_q <= dbg_mode ? ram_rdata : reg0_next;
      idx_q  <= dbg_mode ? 8'(scan_idx) : 8'd0;
      div    <= (!dbg_mode || div_tc) ? '0 : div + 1'b1;
      if (dbg_rise) scan_idx <= '0;
      else if (dbg_mode && div_tc) scan_idx <= scan_idx == IW'(SCAN_LEN - 1) ? '0 : scan_idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_dbus_mmio_ctrl.sv
// tb_dbus_mmio_ctrl: scoreboard bench for dbus_mmio_ctrl with a behavioural 1-cycle RAM.
module tb_dbus_mmio_ctrl;
  localparam logic [31:0] MB = 32'hFFFF_0000;
  logic        m_clock = 0, p_reset = 1, mode = 0, core_read = 0, core_write = 0;
  logic [31:0] core_daddr = 0, core_wdata = 0, ram_rdata = 0;
  logic [31:0] core_rdata, ram_addr, ram_wdata, disp_data;
  logic [7:0]  disp_idx;
  logic        core_stall, ram_rden, ram_wren, dbg_mode;
  int          total = 0, bad = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mem [1024];
  logic [1023:0] wvld = '0;
  logic [31:0] smem [1024];
  logic [31:0] mregs [4];

  always #5 m_clock = ~m_clock;

  dbus_mmio_ctrl #(.DW(32), .SYNC_N(2), .MMIO_BASE(MB), .NREG(4), .SCAN_BASE(32'h200),
                   .SCAN_LEN(3), .SCAN_DIV(4)) dut (
    .m_clock(m_clock), .p_reset(p_reset), .mode(mode), .core_daddr(core_daddr),
    .core_wdata(core_wdata), .core_read(core_read), .core_write(core_write),
    .core_rdata(core_rdata), .core_stall(core_stall), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rden(ram_rden), .ram_wren(ram_wren), .ram_rdata(ram_rdata),
    .disp_data(disp_data), .disp_idx(disp_idx), .dbg_mode(dbg_mode));

  function automatic logic [31:0] init_word(int i);
    return i == 16 ? 32'hDEAD_BEEF : 32'hA500_0000 | 32'(i);
  endfunction

  always @(posedge m_clock) begin
    if (ram_wren) begin
      mem[ram_addr[11:2]] <= ram_wdata;
      wvld[ram_addr[11:2]] <= 1'b1;
    end
    if (ram_rden) ram_rdata <= wvld[ram_addr[11:2]] ? mem[ram_addr[11:2]] : init_word(int'(ram_addr[11:2]));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    logic [31:0] o;
    o = a - MB;
    if (a >= MB) return (o[1:0] == 2'b00 && o < 32'd16) ? mregs[o[3:2]] : 32'h0;
    return smem[a[11:2]];
  endfunction

  task automatic model_wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] o;
    o = a - MB;
    if (a >= MB) begin
      if (o[1:0] == 2'b00 && o < 32'd16) mregs[o[3:2]] = d;
    end else smem[a[11:2]] = d;
  endtask

  task automatic op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d, input string tag);
    core_read = rd; core_write = wr; core_daddr = a; core_wdata = d;
    exp_q.push_back((rd && !wr) ? model_rd(a) : 32'h0);
    if (wr) model_wr(a, d);
    #1;
    if (a < MB && (rd || wr)) begin
      check({tag, ".wren"}, 32'(ram_wren), 32'(wr));
      check({tag, ".rden"}, 32'(ram_rden), 32'(rd && !wr));
      check({tag, ".addr"}, ram_addr, a);
    end else check({tag, ".ramidle"}, ram_addr | ram_wdata | 32'({ram_rden, ram_wren}), 32'h0);
    @(posedge m_clock); #1;
    core_read = 0; core_write = 0; core_daddr = 0; core_wdata = 0;
    check({tag, ".rdata"}, core_rdata, exp_q.pop_front());
  endtask

  initial begin
    logic [31:0] a;
    int kind;
    for (int i = 0; i < 1024; i++) smem[i] = init_word(i);
    for (int i = 0; i < 4; i++) mregs[i] = 32'h0;
    #12;
    check("rst.dbg", 32'(dbg_mode), 32'h0);
    check("rst.stall", 32'(core_stall), 32'h0);
    check("rst.rdata", core_rdata, 32'h0);
    check("rst.disp", disp_data, 32'h0);
    check("rst.idx", 32'(disp_idx), 32'h0);
    @(posedge m_clock); #1 p_reset = 0;
    @(posedge m_clock); #1;
    op(0, 1, MB, 32'h1234_5678, "wr0");
    op(1, 0, MB, 32'h0, "rd0");
    check("disp0", disp_data, 32'h1234_5678);
    op(1, 0, 32'h40, 32'h0, "rdram");
    op(0, 0, 32'h0, 32'h0, "idle");
    op(0, 1, MB + 32'd16, 32'hCAFE_F00D, "wroob");
    op(1, 0, MB + 32'd16, 32'h0, "rdoob");
    for (int i = 0; i < 4; i++) op(1, 0, MB + 32'(4 * i), 32'h0, "rdreg");
    op(0, 1, MB + 32'd1, 32'h0BAD_0001, "wrmis");
    op(1, 0, MB + 32'd1, 32'h0, "rdmis");
    op(1, 0, MB, 32'h0, "rd0b");
    op(0, 1, MB + 32'd8, 32'h2222_3333, "wr2");
    op(1, 0, MB + 32'd8, 32'h0, "rd2");
    op(1, 1, 32'h44, 32'h5555_AAAA, "rdwr");
    op(1, 0, 32'h44, 32'h0, "rd44");
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0, 1: a = 32'h40 + 32'(4 * $urandom_range(0, 7));
        2: a = MB + 32'(4 * $urandom_range(0, 5));
        default: a = MB + 32'($urandom_range(0, 23));
      endcase
      kind = int'($urandom_range(0, 3));
      op(kind == 1 || kind == 3, kind >= 2, a, $urandom, "rnd");
    end
    mode = 1;
    @(posedge m_clock); #1;
    check("sync1", 32'(dbg_mode), 32'h0);
    op(1, 0, 32'h48, 32'h0, "lastrun");
    check("dbg.on", 32'(dbg_mode), 32'h1);
    check("dbg.stall", 32'(core_stall), 32'h1);
    for (int k = 0; k < 16; k++) begin
      if (k == 1) begin core_write = 1; core_daddr = MB; core_wdata = 32'h0000_0BAD; end
      #1;
      check("scan.addr", ram_addr, 32'h200 + 32'(4 * ((k / 4) % 3)));
      check("scan.rw", 32'({ram_rden, ram_wren}), 32'h2);
      check("scan.stall", 32'(core_stall), 32'h1);
      if (k >= 1) check("scan.idx", 32'(disp_idx), 32'((k - 1) / 4 % 3));
      if (k >= 2) check("scan.disp", disp_data, smem[(32'h200 + 32'(4 * ((k - 2) / 4 % 3))) >> 2]);
      @(posedge m_clock); #1;
      core_write = 0; core_daddr = 0; core_wdata = 0;
    end
    mode = 0;
    repeat (3) @(posedge m_clock);
    #1;
    check("exit.dbg", 32'(dbg_mode), 32'h0);
    check("exit.stall", 32'(core_stall), 32'h0);
    check("exit.disp", disp_data, mregs[0]);
    check("exit.idx", 32'(disp_idx), 32'h0);
    op(1, 0, MB, 32'h0, "rdafter");
    mode = 1;
    repeat (8) @(posedge m_clock);
    #1 p_reset = 1;
    #1;
    check("mrst.dbg", 32'(dbg_mode), 32'h0);
    check("mrst.stall", 32'(core_stall), 32'h0);
    check("mrst.disp", disp_data, 32'h0);
    check("mrst.idx", 32'(disp_idx), 32'h0);
    check("mrst.rdata", core_rdata, 32'h0);
    check("mrst.rden", 32'(ram_rden), 32'h0);
    #2 p_reset = 0;
    @(posedge m_clock); #1;
    check("mrst.sync1", 32'(dbg_mode), 32'h0);
    @(posedge m_clock); #1;
    check("mrst.sync2", 32'(dbg_mode), 32'h1);
    check("mrst.addr", ram_addr, 32'h200);
    repeat (4) @(posedge m_clock);
    #1;
    check("mrst.addr1", ram_addr, 32'h204);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
